lean_conv_monitor: RTL

- Parametrised, synthesizable convergence monitor for the Segway balance loop.
- Watches one signed angle (theta_platform) and NCH signed wheel-speed channels (omega_lft/omega_rght, plus more if present).
- After an arm pulse, declares PASS once the angle stays within band and all channels agree within a tolerance for a dwell window. Declares FAIL on timeout.
- Bound into the full-chip bench and the post-synthesis bench; it replaces one-shot sampled checks with windowed, timed checks.

---
 rtl/lean_conv_monitor.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/lean_conv_monitor.sv
// lean_conv_monitor: after an arm pulse, waits for angle in band and channels matched for a dwell window
// (PASS) or times out (FAIL). Statistics outputs are built only when CONV_MON_STATS_EN is defined.
module lean_conv_monitor #(
    parameter int WIDTH          = 16,
    parameter int NCH            = 2,
    parameter int ANG_THRESH     = 250,
    parameter int MATCH_TOL      = 0,
    parameter int DWELL_CYCLES   = 4096,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    arm,
    input  logic signed [WIDTH-1:0]                 angle,
    input  logic        [NCH*WIDTH-1:0]             chan,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    pass,
    output logic        [1:0]                       fail_code,
    output logic        [$clog2(DWELL_CYCLES+1)-1:0] dwell_cnt,
    output logic        [WIDTH:0]                   peak_abs_angle,
    output logic        [15:0]                      drop_cnt
);

    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WIDTH:0] LP_ANG_THR  = (WIDTH+1)'(ANG_THRESH);
    localparam logic [WIDTH:0] LP_TOL      = (WIDTH+1)'(MATCH_TOL);
    localparam logic [DW-1:0]  LP_DWELL    = DW'(DWELL_CYCLES);
    localparam logic [DW-1:0]  LP_DWELL_M1 = DW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0]  LP_TMO_M1   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t                   r_state, w_state_nxt;
    logic [TW-1:0]            r_timer, w_timer_nxt;
    logic [DW-1:0]            r_dwell, w_dwell_nxt;
    logic                     r_pass, w_pass_nxt;
    logic [1:0]               r_fc, w_fc_nxt;

    logic signed [WIDTH:0]    w_ang_ext;
    logic        [WIDTH:0]    w_abs_ang;
    logic signed [WIDTH-1:0]  w_ch, w_max, w_min;
    logic signed [WIDTH:0]    w_max_ext, w_min_ext;
    logic        [WIDTH:0]    w_spread;
    logic                     w_ang_ok, w_match_ok, w_in_band, w_dwell_hit;

    // One extra bit keeps |most-negative| representable.
    assign w_ang_ext = {angle[WIDTH-1], angle};
    assign w_abs_ang = w_ang_ext[WIDTH] ? $unsigned(-w_ang_ext) : $unsigned(w_ang_ext);

    always_comb begin
        w_ch  = '0;
        w_max = chan[WIDTH-1:0];
        w_min = chan[WIDTH-1:0];
        for (int k = 1; k < NCH; k++) begin
            w_ch = chan[k*WIDTH +: WIDTH];
            if (w_ch > w_max) w_max = w_ch;
            if (w_ch < w_min) w_min = w_ch;
        end
    end

    assign w_max_ext   = {w_max[WIDTH-1], w_max};
    assign w_min_ext   = {w_min[WIDTH-1], w_min};
    assign w_spread    = $unsigned(w_max_ext - w_min_ext);
    assign w_ang_ok    = (w_abs_ang <= LP_ANG_THR);
    assign w_match_ok  = (w_spread <= LP_TOL);
    assign w_in_band   = w_ang_ok && w_match_ok;
    assign w_dwell_hit = w_in_band && (r_dwell == LP_DWELL_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_dwell <= '0;
            r_pass  <= 1'b0;
            r_fc    <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_dwell <= w_dwell_nxt;
            r_pass  <= w_pass_nxt;
            r_fc    <= w_fc_nxt;
        end
    end

    // arm restarts from any state; dwell completion takes priority over timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_dwell_nxt = r_dwell;
        w_pass_nxt  = r_pass;
        w_fc_nxt    = r_fc;
        if (arm) begin
            w_state_nxt = EVAL;
            w_timer_nxt = '0;
            w_dwell_nxt = '0;
            w_pass_nxt  = 1'b0;
            w_fc_nxt    = 2'b00;
        end else begin
            case (r_state)
                EVAL: begin
                    w_timer_nxt = r_timer + TW'(1);
                    if (w_dwell_hit) begin
                        w_dwell_nxt = LP_DWELL;
                        w_state_nxt = DONE;
                        w_pass_nxt  = 1'b1;
                        w_fc_nxt    = 2'b00;
                    end else if (w_in_band) begin
                        w_dwell_nxt = r_dwell + DW'(1);
                    end else begin
                        w_dwell_nxt = '0;
                    end
                    if (!w_dwell_hit && (r_timer == LP_TMO_M1)) begin
                        w_state_nxt = DONE;
                        w_pass_nxt  = 1'b0;
                        w_fc_nxt    = {~w_match_ok, ~w_ang_ok};
                    end
                end
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    assign busy      = (r_state == EVAL);
    assign done      = (r_state == DONE);
    assign pass      = r_pass;
    assign fail_code = r_fc;
    assign dwell_cnt = r_dwell;

`ifdef CONV_MON_STATS_EN
    logic [WIDTH:0] r_peak;
    logic [15:0]    r_drops;
    logic           r_prev_in_band;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak         <= '0;
            r_drops        <= '0;
            r_prev_in_band <= 1'b0;
        end else if (arm) begin
            r_peak         <= '0;
            r_drops        <= '0;
            r_prev_in_band <= 1'b0;
        end else if (r_state == EVAL) begin
            if (w_abs_ang > r_peak) r_peak <= w_abs_ang;
            if (r_prev_in_band && !w_in_band && (r_drops != 16'hFFFF)) r_drops <= r_drops + 16'd1;
            r_prev_in_band <= w_in_band;
        end
    end

    assign peak_abs_angle = r_peak;
    assign drop_cnt       = r_drops;
`else
    assign peak_abs_angle = '0;
    assign drop_cnt       = '0;
`endif

endmodule
